// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter for the SID mixer output: mono sample duplicated to both slots, BCLK/LRCLK derived from CLK.
// Optional macro SID_I2S_GAIN_EN adds a 2-bit GAIN input (saturating left shift applied at frame load).
module sid_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [15:0] SAMPLE_IN,
    input  logic        SAMPLE_VALID,
`ifdef SID_I2S_GAIN_EN
    input  logic [1:0]  GAIN,
`endif
    output logic        BCLK,
    output logic        LRCLK,
    output logic        SDATA,
    output logic        FRAME_STROBE
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);

`ifdef SID_I2S_GAIN_EN
    // Shift left by g bits, clamping to the signed 16-bit range.
    function automatic logic [15:0] apply_gain(input logic [15:0] s, input logic [1:0] g);
        logic signed [18:0] w;
        w = 19'($signed(s)) <<< g;
        if (w > 19'sd32767) begin
            apply_gain = 16'h7FFF;
        end else if (w < -19'sd32768) begin
            apply_gain = 16'h8000;
        end else begin
            apply_gain = w[15:0];
        end
    endfunction
`endif

    logic [CW-1:0] div_cnt_r, div_cnt_d;
    logic          bclk_r, bclk_d;
    logic [4:0]    slot_r, slot_d;
    logic [15:0]   hold_r, hold_d;
    logic [31:0]   shift_r, shift_d;
    logic          lrclk_r, lrclk_d;
    logic          frame_strobe_r, frame_strobe_d;
    logic          tc_s, fall_s;
    logic [4:0]    slot_next_s, lr_slot_s;
    logic [15:0]   word_s;

`ifdef SID_I2S_GAIN_EN
    assign word_s = apply_gain(hold_r, GAIN);
`else
    assign word_s = hold_r;
`endif

    // Divider, slot sequencing, frame load and shifter next-state.
    always_comb begin
        tc_s           = (div_cnt_r == DIV_LAST);
        fall_s         = tc_s & bclk_r;
        slot_next_s    = slot_r + 5'd1;
        lr_slot_s      = slot_next_s + 5'd1;
        div_cnt_d      = tc_s ? {CW{1'b0}} : (div_cnt_r + CW'(1));
        bclk_d         = tc_s ? ~bclk_r : bclk_r;
        hold_d         = SAMPLE_VALID ? SAMPLE_IN : hold_r;
        slot_d         = slot_r;
        shift_d        = shift_r;
        lrclk_d        = lrclk_r;
        frame_strobe_d = 1'b0;
        if (fall_s) begin
            slot_d  = slot_next_s;
            // LRCLK switches one BCLK ahead of the slot it announces.
            lrclk_d = lr_slot_s[4];
            if (slot_r == 5'd31) begin
                shift_d        = {word_s, word_s};
                frame_strobe_d = 1'b1;
            end else begin
                shift_d        = {shift_r[30:0], 1'b0};
                frame_strobe_d = 1'b0;
            end
        end else begin
            slot_d         = slot_r;
            shift_d        = shift_r;
            lrclk_d        = lrclk_r;
            frame_strobe_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            div_cnt_r      <= {CW{1'b0}};
            bclk_r         <= 1'b0;
            slot_r         <= 5'd31;
            hold_r         <= 16'h0000;
            shift_r        <= 32'h0000_0000;
            lrclk_r        <= 1'b0;
            frame_strobe_r <= 1'b0;
        end else begin
            div_cnt_r      <= div_cnt_d;
            bclk_r         <= bclk_d;
            slot_r         <= slot_d;
            hold_r         <= hold_d;
            shift_r        <= shift_d;
            lrclk_r        <= lrclk_d;
            frame_strobe_r <= frame_strobe_d;
        end
    end

    // The shifter MSB always holds the bit currently on the wire.
    assign SDATA        = shift_r[31];
    assign BCLK         = bclk_r;
    assign LRCLK        = lrclk_r;
    assign FRAME_STROBE = frame_strobe_r;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Scoreboard bench for sid_i2s_tx: a model queues the word each frame must carry, a monitor checks the serial stream.
module tb_sid_i2s_tx;

    localparam int D = 2;
    localparam int FRAME = 64 * D;

    logic        clk;
    logic        rst_n;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [1:0]  gain;
    logic        bclk, lrclk, sdata, frame_strobe;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt;
    logic [15:0] model_hold;
    logic [15:0] exp_q[$];

    sid_i2s_tx #(.BCLK_DIV(D)) dut (
        .CLK(clk),
        .RESETn(rst_n),
        .SAMPLE_IN(sample_in),
        .SAMPLE_VALID(sample_valid),
`ifdef SID_I2S_GAIN_EN
        .GAIN(gain),
`endif
        .BCLK(bclk),
        .LRCLK(lrclk),
        .SDATA(sdata),
        .FRAME_STROBE(frame_strobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
        end
    endtask

    // A frame loads on the first fall event (edge 2D) and then every 32 BCLK periods.
    function automatic bit is_load(input int e);
        return (e >= 2 * D) && (((e - 2 * D) % FRAME) == 0);
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] h, input int g);
        int v;
        v = int'($signed(h)) * (1 << g);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic int cur_gain();
`ifdef SID_I2S_GAIN_EN
        return int'(gain);
`else
        return 0;
`endif
    endfunction

    // Reference model: latest strobed sample wins; at each load edge the held value is queued.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt   <= 0;
            model_hold <= 16'h0000;
            exp_q.delete();
        end else begin
            edge_cnt <= edge_cnt + 1;
            if (is_load(edge_cnt + 1)) exp_q.push_back(ref_word(model_hold, cur_gain()));
            if (sample_valid) model_hold <= sample_in;
        end
    end

    // Monitor: checks every CLK on the falling edge against the queued frame word.
    initial begin
        bit          active;
        int          fstart, e, k;
        logic [15:0] cur;
        active = 1'b0;
        fstart = 0;
        cur    = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                e = edge_cnt;
                check("bclk", 32'(bclk), 32'((e / D) % 2));
                check("frame_strobe", 32'(frame_strobe), 32'(is_load(e)));
                if (is_load(e)) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        cur    = exp_q.pop_front();
                        active = 1'b1;
                        fstart = e;
                    end
                end
                if (active) begin
                    k = (e - fstart) / (2 * D);
                    check("sdata", 32'(sdata), 32'(cur[15 - (k % 16)]));
                    check("lrclk", 32'(lrclk), 32'(((k + 1) % 32) >= 16));
                end else begin
                    check("sdata_idle", 32'(sdata), 32'd0);
                    check("lrclk_idle", 32'(lrclk), 32'd0);
                end
            end
        end
    end

    task automatic wait_edge(input int target);
        int n;
        n = 0;
        while (edge_cnt != target && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (edge_cnt != target) check("wait_edge_timeout", 32'(edge_cnt), 32'(target));
    endtask

    // Present a one-cycle strobe so that it is sampled on edge e.
    task automatic strobe_at(input int e, input logic [15:0] v);
        wait_edge(e - 1);
        sample_in    = v;
        sample_valid = 1'b1;
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        sample_in    = 16'($urandom);
    endtask

    initial begin
        int t;
        rst_n        = 1'b0;
        sample_in    = 16'h0000;
        sample_valid = 1'b0;
        gain         = 2'd0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Frame 0 sends 0, frame 1 sends 0x8001.
        strobe_at(50, 16'h8001);
        // Latest of two strobes wins, then repeats.
        strobe_at(140, 16'h1234);
        strobe_at(200, 16'hABCD);
        // Strobe on the exact load edge of frame 4 goes to frame 5.
        strobe_at(300, 16'h0F0F);
        strobe_at(4 + 4 * FRAME, 16'h5555);
        // Gain cases (no effect without the optional feature).
        gain = 2'd2;
        strobe_at(700, 16'h1000);
        strobe_at(800, 16'h3000);
        strobe_at(930, 16'hC000);
        gain = 2'd0;
        strobe_at(1060, 16'h1234);
        wait_edge(1160);

        // Randomised traffic: sparse strobes, random values and gain.
        while (edge_cnt < 1700) begin
            @(posedge clk);
            #2;
            sample_valid = ($urandom_range(0, 11) == 0);
            sample_in    = 16'($urandom);
            gain         = 2'($urandom_range(0, 3));
        end
        sample_valid = 1'b0;

        // Reset in the middle of slot 20 while BCLK is high.
        t = edge_cnt + 1;
        while (((t - 4) % FRAME) != 82) t++;
        wait_edge(t);
        rst_n = 1'b0;
        #1;
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrclk", 32'(lrclk), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_frame_strobe", 32'(frame_strobe), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        gain  = 2'd0;

        // First frame after reset carries 0, the next the new sample.
        strobe_at(30, 16'h2468);
        wait_edge(4 + 2 * FRAME + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
